// File: rtl/weight_read_ctrl.sv
// Weight-memory read sequencer for one neuron: pairs each accepted input sample
// with its weight (1-cycle memory latency) and flags the last pair of a pass.
module weight_read_ctrl #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [dataWidth-1:0]    in_data,
    output logic                    in_ready,
    output logic                    ren,
    output logic [addressWidth:0]   raddr,
    input  logic [dataWidth-1:0]    wout,
    output logic                    pair_valid,
    output logic [dataWidth-1:0]    pair_x,
    output logic [dataWidth-1:0]    pair_w,
    output logic                    pair_last,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [addressWidth:0] LAST_ADDR = (addressWidth+1)'(numWeight - 1);
    localparam logic [addressWidth:0] ADDR_ONE  = (addressWidth+1)'(1);
    localparam logic [addressWidth:0] ADDR_ZERO = (addressWidth+1)'(0);

    logic [1:0]              state_r;
    logic [1:0]              next_state_s;
    logic [addressWidth:0]   addr_cnt_r;
    logic                    accept_s;
    logic                    last_s;
    logic                    pair_valid_r;
    logic                    pair_last_r;
    logic [dataWidth-1:0]    pair_x_r;
    logic                    busy_r;
    logic                    done_r;

    // Handshake decode: a sample is taken only while running.
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        if (state_r == RUN) begin
            accept_s = in_valid;
        end else begin
            accept_s = 1'b0;
        end
        if (addr_cnt_r == LAST_ADDR) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s && last_s) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = RUN;
                end
            end
            DRAIN:   next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Read address counter: cleared on pass start and on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt_r <= ADDR_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        addr_cnt_r <= ADDR_ZERO;
                    end else begin
                        addr_cnt_r <= addr_cnt_r;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        addr_cnt_r <= addr_cnt_r + ADDR_ONE;
                    end else begin
                        addr_cnt_r <= addr_cnt_r;
                    end
                end
                DONE:    addr_cnt_r <= ADDR_ZERO;
                default: addr_cnt_r <= addr_cnt_r;
            endcase
        end
    end

    // Sample register lines up with the weight arriving one cycle after the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_valid_r <= 1'b0;
            pair_last_r  <= 1'b0;
            pair_x_r     <= '0;
        end else begin
            pair_valid_r <= accept_s;
            pair_last_r  <= accept_s && last_s;
            if (accept_s) begin
                pair_x_r <= in_data;
            end else begin
                pair_x_r <= pair_x_r;
            end
        end
    end

    // Status flags decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == RUN) || (next_state_s == DRAIN);
            done_r <= (next_state_s == DONE);
        end
    end

    assign in_ready   = (state_r == RUN);
    assign ren        = accept_s;
    assign raddr      = addr_cnt_r;
    assign pair_valid = pair_valid_r;
    assign pair_x     = pair_x_r;
    assign pair_w     = wout;
    assign pair_last  = pair_last_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_weight_read_ctrl.sv
// Directed bench for weight_read_ctrl: a 4-weight instance and a 1-weight
// instance, each fed by a 1-cycle-latency weight memory model.
module tb_weight_read_ctrl;

    logic        clk;
    logic        rst_n;

    logic        start4, in_valid4, in_ready4, ren4, pair_valid4, pair_last4, busy4, done4;
    logic [15:0] in_data4, wout4, pair_x4, pair_w4;
    logic [10:0] raddr4;

    logic        start1, in_valid1, in_ready1, ren1, pair_valid1, pair_last1, busy1, done1;
    logic [15:0] in_data1, wout1, pair_x1, pair_w1;
    logic [10:0] raddr1;

    int n_checks;
    int n_fail;

    weight_read_ctrl #(.numWeight(4), .addressWidth(10), .dataWidth(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid4), .in_data(in_data4),
        .in_ready(in_ready4), .ren(ren4), .raddr(raddr4), .wout(wout4),
        .pair_valid(pair_valid4), .pair_x(pair_x4), .pair_w(pair_w4),
        .pair_last(pair_last4), .busy(busy4), .done(done4)
    );

    weight_read_ctrl #(.numWeight(1), .addressWidth(10), .dataWidth(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .ren(ren1), .raddr(raddr1), .wout(wout1),
        .pair_valid(pair_valid1), .pair_x(pair_x1), .pair_w(pair_w1),
        .pair_last(pair_last1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight memories: w[i] = 0x0100+i and 0x0200+i, read data valid after the read edge.
    always @(posedge clk) begin
        if (ren4) wout4 <= 16'h0100 + {5'd0, raddr4};
        if (ren1) wout1 <= 16'h0200 + {5'd0, raddr1};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full pass on the 4-weight instance; pat bit c is in_valid in RUN cycle c.
    task automatic run_pass(input logic [15:0] pat, input int len, input logic [15:0] base,
                            input logic noisy);
        int          k;
        logic        prev_acc;
        int          prevk;
        logic [15:0] prevd;
        logic        v;
        k = 0;
        prev_acc = 1'b0;
        prevk = 0;
        prevd = 16'h0;
        next_cycle();
        start4 = 1'b1;
        in_valid4 = 1'b1;
        in_data4 = 16'hdead;
        #1;
        check_eq("idle_ren_with_start", 32'(ren4), 32'd0);
        check_eq("idle_in_ready", 32'(in_ready4), 32'd0);
        for (int c = 0; c < len; c++) begin
            next_cycle();
            v = pat[c];
            in_valid4 = v;
            in_data4 = base + 16'(k);
            start4 = noisy;
            #1;
            if (prev_acc) begin
                check_eq("pair_valid", 32'(pair_valid4), 32'd1);
                check_eq("pair_x", 32'(pair_x4), 32'(prevd));
                check_eq("pair_w", 32'(pair_w4), 32'(16'h0100 + 16'(prevk)));
                check_eq("pair_last_early", 32'(pair_last4), 32'd0);
            end else begin
                check_eq("pair_valid_gap", 32'(pair_valid4), 32'd0);
            end
            check_eq("run_ren", 32'(ren4), 32'(v));
            check_eq("run_raddr", 32'(raddr4), 32'(k));
            check_eq("run_in_ready", 32'(in_ready4), 32'd1);
            check_eq("run_busy", 32'(busy4), 32'd1);
            check_eq("run_done", 32'(done4), 32'd0);
            prev_acc = v;
            prevk = k;
            prevd = base + 16'(k);
            if (v) k++;
        end
        // DRAIN: final pair presented, no further reads even with in_valid high.
        next_cycle();
        in_valid4 = noisy;
        start4 = noisy;
        #1;
        check_eq("drain_pair_valid", 32'(pair_valid4), 32'd1);
        check_eq("drain_pair_x", 32'(pair_x4), 32'(base + 16'd3));
        check_eq("drain_pair_w", 32'(pair_w4), 32'h0103);
        check_eq("drain_pair_last", 32'(pair_last4), 32'd1);
        check_eq("drain_ren", 32'(ren4), 32'd0);
        check_eq("drain_in_ready", 32'(in_ready4), 32'd0);
        check_eq("drain_busy", 32'(busy4), 32'd1);
        check_eq("drain_done", 32'(done4), 32'd0);
        next_cycle();
        #1;
        check_eq("done_pulse", 32'(done4), 32'd1);
        check_eq("done_pair_valid", 32'(pair_valid4), 32'd0);
        check_eq("done_busy", 32'(busy4), 32'd0);
        check_eq("done_ren", 32'(ren4), 32'd0);
        next_cycle();
        start4 = 1'b0;
        in_valid4 = 1'b0;
        #1;
        check_eq("idle_after_done", 32'(done4), 32'd0);
        check_eq("idle_after_busy", 32'(busy4), 32'd0);
        check_eq("idle_after_raddr", 32'(raddr4), 32'd0);
        next_cycle();
        check_eq("single_done", 32'(done4), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start4 = 1'b0; in_valid4 = 1'b0; in_data4 = 16'h0;
        start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 16'h0;
        wout4 = 16'h0; wout1 = 16'h0;
        next_cycle();
        next_cycle();
        check_eq("rst_pair_valid", 32'(pair_valid4), 32'd0);
        check_eq("rst_pair_last", 32'(pair_last4), 32'd0);
        check_eq("rst_pair_x", 32'(pair_x4), 32'd0);
        check_eq("rst_busy", 32'(busy4), 32'd0);
        check_eq("rst_done", 32'(done4), 32'd0);
        check_eq("rst_ren", 32'(ren4), 32'd0);
        check_eq("rst_raddr", 32'(raddr4), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready4), 32'd0);
        rst_n = 1'b1;

        // in_valid in IDLE without start is ignored.
        next_cycle();
        in_valid4 = 1'b1;
        #1;
        check_eq("idle_iv_ren", 32'(ren4), 32'd0);
        check_eq("idle_iv_in_ready", 32'(in_ready4), 32'd0);
        next_cycle();
        check_eq("idle_iv_pair_valid", 32'(pair_valid4), 32'd0);
        check_eq("idle_iv_busy", 32'(busy4), 32'd0);
        in_valid4 = 1'b0;

        // Full-throughput pass, then a pass with stalls, then one with start/in_valid noise.
        run_pass(16'b1111, 4, 16'h0010, 1'b0);
        run_pass(16'b1011001, 7, 16'h0020, 1'b0);
        run_pass(16'b1111, 4, 16'h0030, 1'b1);

        // Reset after two accepts aborts the pass without a done pulse.
        next_cycle();
        start4 = 1'b1;
        next_cycle();
        start4 = 1'b0;
        in_valid4 = 1'b1;
        in_data4 = 16'h0040;
        next_cycle();
        in_data4 = 16'h0041;
        next_cycle();
        in_valid4 = 1'b0;
        #1;
        check_eq("pre_abort_raddr", 32'(raddr4), 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("abort_pair_valid", 32'(pair_valid4), 32'd0);
        check_eq("abort_busy", 32'(busy4), 32'd0);
        check_eq("abort_raddr", 32'(raddr4), 32'd0);
        check_eq("abort_pair_x", 32'(pair_x4), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_eq("abort_no_done", 32'(done4), 32'd0);
        end
        run_pass(16'b1111, 4, 16'h0050, 1'b0);

        // Single-weight instance: first accept is also the last.
        next_cycle();
        start1 = 1'b1;
        next_cycle();
        start1 = 1'b0;
        in_valid1 = 1'b1;
        in_data1 = 16'h0055;
        #1;
        check_eq("n1_ren", 32'(ren1), 32'd1);
        check_eq("n1_raddr", 32'(raddr1), 32'd0);
        next_cycle();
        in_valid1 = 1'b0;
        #1;
        check_eq("n1_pair_valid", 32'(pair_valid1), 32'd1);
        check_eq("n1_pair_last", 32'(pair_last1), 32'd1);
        check_eq("n1_pair_x", 32'(pair_x1), 32'h0055);
        check_eq("n1_pair_w", 32'(pair_w1), 32'h0200);
        check_eq("n1_in_ready", 32'(in_ready1), 32'd0);
        check_eq("n1_busy", 32'(busy1), 32'd1);
        next_cycle();
        check_eq("n1_done", 32'(done1), 32'd1);
        check_eq("n1_done_pv", 32'(pair_valid1), 32'd0);
        next_cycle();
        check_eq("n1_idle_done", 32'(done1), 32'd0);
        check_eq("n1_idle_busy", 32'(busy1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
